vga_pixel_gen: RTL and testbench

VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_sync_delay.sv | 20 ++
 rtl/vga_pixel_gen.sv | 122 ++++++++++++
 tb/tb_vga_pixel_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel generator: display defaults, colour width,
// bar colour table and box direction encoding.
package vga_pkg;
  localparam int H_DISP_DEF = 1280;
  localparam int V_DISP_DEF = 1024;
  localparam int COLOR_W    = 10;

  // {r,g,b} on/off per bar; index 0 is the leftmost bar (white) ... 7 (black)
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef enum logic [1:0] {DR, DL, UR, UL} dir_t;
endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that keeps sync signals aligned with the pixel pipe.
// Resets to all ones so active-low syncs come out idle.
module vga_sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) pipe <= '1;
    else        pipe <= {pipe[DEPTH-2:0], d};
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_pixel_gen.sv
// Colour-bar pattern generator with optional bouncing white box, 2-cycle latency.
// Define VGA_BOUNCE_BOX_EN to compile in the box position, direction FSM and overlay.
module vga_pixel_gen
  import vga_pkg::*;
#(
  parameter int H_DISP   = H_DISP_DEF,
  parameter int V_DISP   = V_DISP_DEF,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_enable,
  input  logic [31:0]        Xpix,
  input  logic [31:0]        Ypix,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               freeze,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B
);
  localparam int BAR_W = H_DISP / 8;

  logic [2:0] bar_idx;
  logic       en1, hit1, vs_q, hit;
  logic [2:0] rgb;
  logic [1:0] sync_q;

`ifdef VGA_BOUNCE_BOX_EN
  logic [15:0] bx, by, nbx, nby;
  dir_t        dir;
  logic        tick, right, down, nr, nd;

  assign tick  = vs_q & ~vsync_in;
  assign right = (dir == DR) || (dir == UR);
  assign down  = (dir == DR) || (dir == DL);

  // Bounce tests are widened to 32 bits so bx+BOX_SIZE+STEP cannot wrap.
  always_comb begin
    nr  = right;
    nd  = down;
    nbx = bx;
    nby = by;
    if (right) begin
      if ({16'd0, bx} + 32'(BOX_SIZE) + 32'(STEP) > 32'(H_DISP)) begin
        nr = 1'b0; nbx = bx - 16'(STEP);
      end else nbx = bx + 16'(STEP);
    end else if ({16'd0, bx} < 32'(STEP)) begin
      nr = 1'b1; nbx = bx + 16'(STEP);
    end else nbx = bx - 16'(STEP);
    if (down) begin
      if ({16'd0, by} + 32'(BOX_SIZE) + 32'(STEP) > 32'(V_DISP)) begin
        nd = 1'b0; nby = by - 16'(STEP);
      end else nby = by + 16'(STEP);
    end else if ({16'd0, by} < 32'(STEP)) begin
      nd = 1'b1; nby = by + 16'(STEP);
    end else nby = by - 16'(STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bx  <= '0;
      by  <= '0;
      dir <= DR;
    end else if (tick && !freeze) begin
      bx  <= nbx;
      by  <= nby;
      dir <= nd ? (nr ? DR : DL) : (nr ? UR : UL);
    end
  end

  assign hit = ({16'd0, bx} <= Xpix) && (Xpix < {16'd0, bx} + 32'(BOX_SIZE)) &&
               ({16'd0, by} <= Ypix) && (Ypix < {16'd0, by} + 32'(BOX_SIZE));
`else
  logic unused;
  assign hit    = 1'b0;
  assign unused = ^{freeze, vs_q};
`endif

  // Stage 1: bar index, box hit, qualified enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_idx <= '0;
      en1     <= 1'b0;
      hit1    <= 1'b0;
      vs_q    <= 1'b1;
    end else begin
      bar_idx <= 3'(Xpix / 32'(BAR_W));
      en1     <= disp_enable && (Xpix < 32'(H_DISP)) && (Ypix < 32'(V_DISP));
      hit1    <= hit;
      vs_q    <= vsync_in;
    end
  end

  assign rgb = hit1 ? 3'b111 : BAR_RGB[bar_idx];

  // Stage 2: colour mux
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= (en1 && rgb[2]) ? '1 : '0;
      G <= (en1 && rgb[1]) ? '1 : '0;
      B <= (en1 && rgb[0]) ? '1 : '0;
    end
  end

  vga_sync_delay #(.DEPTH(2), .WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hsync_in, vsync_in}),
    .q     (sync_q)
  );

  assign hsync = sync_q[1];
  assign vsync = sync_q[0];
endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: table vectors, directed sync/reset sequences, random
// pixels against a frame-level model; box scenarios when VGA_BOUNCE_BOX_EN is set.
module tb_vga_pixel_gen;
  import vga_pkg::*;

  typedef struct {logic [9:0] r, g, b; logic hs, vs;} exp_t;
  typedef struct {logic de; int x; int y; logic [9:0] r, g, b; string name;} vec_t;

  logic        clk = 1'b0;
  logic        rst_n, disp_enable, hsync_in, vsync_in, freeze, hsync, vsync;
  logic [31:0] xpix, ypix;
  logic [9:0]  r, g, b;

  int   n_cmp = 0, n_bad = 0;
  exp_t q[$];
  int   mbx = 0, mby = 0;
  bit   mr = 1, md = 1, mvs = 1;
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  always #5 clk = ~clk;

  vga_pixel_gen dut (
    .clk(clk), .rst_n(rst_n), .disp_enable(disp_enable), .Xpix(xpix), .Ypix(ypix),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze),
    .hsync(hsync), .vsync(vsync), .R(r), .G(g), .B(b)
  );

`ifdef VGA_BOUNCE_BOX_EN
  logic       hs2, vs2;
  logic [9:0] r2, g2, b2;
  // Square display: both axes hit their limits on the same tick.
  vga_pixel_gen #(.H_DISP(256), .V_DISP(256)) dut2 (
    .clk(clk), .rst_n(rst_n), .disp_enable(disp_enable), .Xpix(xpix), .Ypix(ypix),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .freeze(freeze),
    .hsync(hs2), .vsync(vs2), .R(r2), .G(g2), .B(b2)
  );
`endif

  function automatic logic [9:0] lvl(logic on);
    return on ? 10'h3FF : 10'h000;
  endfunction

  function automatic exp_t model_px(logic de, int x, int y);
    exp_t e;
    logic [2:0] c;
    if (!de || x >= 1280 || y >= 1024) c = 3'b000;
    else c = bars[x / 160];
`ifdef VGA_BOUNCE_BOX_EN
    if (de && x < 1280 && y < 1024 && x >= mbx && x < mbx + 64 && y >= mby && y < mby + 64)
      c = 3'b111;
`endif
    e.r = lvl(c[2]); e.g = lvl(c[1]); e.b = lvl(c[0]); e.hs = 1'b1; e.vs = 1'b1;
    return e;
  endfunction

  task automatic move(inout int p, inout bit pos, input int lim);
    if (pos) begin
      if (p + 66 > lim) begin pos = 0; p -= 2; end
      else p += 2;
    end else begin
      if (p < 2) begin pos = 1; p += 2; end
      else p -= 2;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare the output due now.
  task automatic cyc(input logic rs, input logic de, input int x, input int y,
                     input logic hs, input logic vs, input logic fr,
                     input exp_t e, input string nm);
    exp_t ex;
    rst_n = rs; disp_enable = de; xpix = 32'(x); ypix = 32'(y);
    hsync_in = hs; vsync_in = vs; freeze = fr;
    if (!rs) begin
      e = '{10'h0, 10'h0, 10'h0, 1'b1, 1'b1};
      q.delete(); q.push_back(e); q.push_back(e);
      mbx = 0; mby = 0; mr = 1; md = 1; mvs = 1;
    end else begin
      e.hs = hs; e.vs = vs;
      q.push_back(e);
      if (mvs && !vs && !fr) begin
        move(mbx, mr, 1280);
        move(mby, md, 1024);
      end
      mvs = vs;
    end
    @(posedge clk); #1;
    ex = q[q.size() - 2];
    n_cmp++;
    if ({r, g, b, hsync, vsync} !== {ex.r, ex.g, ex.b, ex.hs, ex.vs}) begin
      n_bad++;
      $display("FAIL %s: got rgb=%h/%h/%h hs=%b vs=%b expected rgb=%h/%h/%h hs=%b vs=%b",
               nm, r, g, b, hsync, vsync, ex.r, ex.g, ex.b, ex.hs, ex.vs);
    end
    if (q.size() > 2) void'(q.pop_front());
  endtask

  task automatic pix(input logic rs, input logic de, input int x, input int y,
                     input logic hs, input logic vs, input logic fr, input string nm);
    cyc(rs, de, x, y, hs, vs, fr, model_px(de, x, y), nm);
  endtask

`ifdef VGA_BOUNCE_BOX_EN
  task automatic frame_tick(input logic fr);
    pix(1, 1, 25, 25, 1, 0, fr, "tick_lo");
    pix(1, 1, 25, 25, 1, 1, fr, "tick_hi");
  endtask
`endif

  initial begin
    vec_t tbl[12];
    exp_t e;
    tbl[0]  = '{1'b1, 0,    500,  10'h3FF, 10'h3FF, 10'h3FF, "bar0_x0"};
    tbl[1]  = '{1'b1, 160,  500,  10'h3FF, 10'h3FF, 10'h000, "bar1_x160"};
    tbl[2]  = '{1'b1, 1279, 500,  10'h000, 10'h000, 10'h000, "bar7_x1279"};
    tbl[3]  = '{1'b1, 320,  500,  10'h000, 10'h3FF, 10'h3FF, "bar2_cyan"};
    tbl[4]  = '{1'b1, 480,  700,  10'h000, 10'h3FF, 10'h000, "bar3_green"};
    tbl[5]  = '{1'b1, 799,  64,   10'h3FF, 10'h000, 10'h3FF, "bar4_edge"};
    tbl[6]  = '{1'b1, 800,  1023, 10'h3FF, 10'h000, 10'h000, "bar5_lastline"};
    tbl[7]  = '{1'b1, 960,  900,  10'h000, 10'h000, 10'h3FF, "bar6_blue"};
    tbl[8]  = '{1'b1, 1280, 500,  10'h000, 10'h000, 10'h000, "x_out"};
    tbl[9]  = '{1'b1, 500,  1024, 10'h000, 10'h000, 10'h000, "y_out"};
    tbl[10] = '{1'b0, 10,   500,  10'h000, 10'h000, 10'h000, "de_low"};
    tbl[11] = '{1'b1, 159,  100,  10'h3FF, 10'h3FF, 10'h3FF, "bar0_edge"};

    pix(0, 0, 0, 0, 1, 1, 0, "reset0");
    pix(0, 0, 0, 0, 1, 1, 0, "reset1");

    foreach (tbl[i]) begin
      e = '{tbl[i].r, tbl[i].g, tbl[i].b, 1'b1, 1'b1};
      cyc(1, tbl[i].de, tbl[i].x, tbl[i].y, 1, 1, 0, e, tbl[i].name);
    end
    for (int i = 0; i < 2; i++) pix(1, 0, 0, 0, 1, 1, 0, "drain");

    // hsync pulse with blanking: must appear on hsync exactly two clocks later
    pix(1, 1, 5, 500, 1, 1, 0, "pre_pulse");
    cyc(1, 0, 10, 500, 0, 1, 0, '{10'h0, 10'h0, 10'h0, 1'b0, 1'b1}, "hsync_pulse");
    for (int i = 0; i < 3; i++) pix(1, 0, 11 + i, 500, 1, 1, 0, "post_pulse");

    // reset asserted mid-line, then recovery
    pix(1, 1, 100, 500, 1, 1, 0, "midline");
    pix(1, 1, 101, 500, 1, 1, 0, "midline");
    pix(0, 1, 102, 500, 0, 1, 0, "rst_midline");
    pix(1, 0, 103, 500, 1, 1, 0, "post_rst_blank");
    for (int i = 0; i < 4; i++) pix(1, 1, 161 + i, 500, 1, 1, 0, "resume");

    for (int i = 0; i < 400; i++)
      pix(1, logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1400)),
          int'($urandom_range(0, 1100)), logic'($urandom_range(0, 9) != 0),
          logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 3) == 0), "random");

`ifdef VGA_BOUNCE_BOX_EN
    pix(0, 0, 0, 0, 1, 1, 0, "box_reset");
    for (int t = 1; t <= 10; t++) frame_tick(0);
    check("bx_10ticks", int'(dut.bx), 20);
    check("by_10ticks", int'(dut.by), 20);
    check("dir_10ticks", int'(dut.dir), int'(DR));
    check("box_pixel_25_25", int'(r), 1023);
    for (int t = 11; t <= 96; t++) frame_tick(0);
    check("sq_bx_96", int'(dut2.bx), 192);
    check("sq_dir_96", int'(dut2.dir), int'(DR));
    frame_tick(0);
    check("sq_bx_97", int'(dut2.bx), 190);
    check("sq_by_97", int'(dut2.by), 190);
    check("sq_dir_97", int'(dut2.dir), int'(UL));
    for (int t = 98; t <= 608; t++) frame_tick(0);
    check("bx_right_limit", int'(dut.bx), 1216);
    check("by_608", int'(dut.by), mby);
    check("dir_608", int'(dut.dir), int'(UR));
    frame_tick(0);
    check("bx_bounce", int'(dut.bx), 1214);
    check("dir_bounce", int'(dut.dir), int'(UL));
    check("by_609", int'(dut.by), mby);
    for (int t = 0; t < 5; t++) frame_tick(1);
    check("bx_frozen", int'(dut.bx), 1214);
    check("by_frozen", int'(dut.by), mby);
    check("dir_frozen", int'(dut.dir), int'(UL));
    for (int i = 0; i < 300; i++)
      pix(1, 1, int'($urandom_range(1100, 1300)), int'($urandom_range(600, 1023)), 1,
          logic'($urandom_range(0, 3) != 0), 1'b0, "box_random");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
